// File: rtl/mem_access_stage.sv
// MEM stage of the LA32R pipeline: forwards ALU results and runs load/store accesses
// over a req/ack data-memory port, with lane alignment, extension, ALE and timeout reporting.
module mem_access_stage #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_st_data,
    input  logic [3:0]  ex_mem_op,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_wa,
    output logic        mem_ready,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [4:0]  wb_rf_wa,
    output logic [31:0] wb_rf_wd,
    output logic        mem_ale,
    output logic        mem_berr
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    op_q;
    logic [1:0]    off_q;
    logic          rf_we_q;
    logic [4:0]    rf_wa_q;

    logic          is_load;
    logic          is_store;
    logic          is_mem;
    logic          misaligned;
    logic [3:0]    st_we;
    logic [31:0]   st_wdata;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;
    logic          timeout_hit;

    assign mem_ready = (state == IDLE);

    // Op bits [1:0] give access size (00 byte, 01 half, 10 word) for both loads and stores.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (ex_mem_op)
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: is_load  = 1'b1;
            4'b0100, 4'b0101, 4'b0110:                   is_store = 1'b1;
            default: ;
        endcase
        is_mem     = is_load | is_store;
        misaligned = is_mem &&
                     (((ex_mem_op[1:0] == 2'b01) && ex_alu_res[0]) ||
                      ((ex_mem_op[1:0] == 2'b10) && (ex_alu_res[1:0] != 2'b00)));

        st_we    = 4'b0000;
        st_wdata = ex_st_data;
        case (ex_mem_op[1:0])
            2'b00: begin
                if (is_store) st_we = 4'b0001 << ex_alu_res[1:0];
                st_wdata = {4{ex_st_data[7:0]}};
            end
            2'b01: begin
                if (is_store) st_we = ex_alu_res[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_st_data[15:0]}};
            end
            default: begin
                if (is_store) st_we = 4'b1111;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ld_data = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
        timeout_hit = (DMEM_TIMEOUT != 0) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 4'b0;
            dmem_addr  <= 32'b0;
            dmem_wdata <= 32'b0;
            wb_valid   <= 1'b0;
            wb_rf_we   <= 1'b0;
            wb_rf_wa   <= 5'b0;
            wb_rf_wd   <= 32'b0;
            mem_ale    <= 1'b0;
            mem_berr   <= 1'b0;
            op_q       <= 4'b0;
            off_q      <= 2'b0;
            rf_we_q    <= 1'b0;
            rf_wa_q    <= 5'b0;
        end else begin
            mem_ale  <= 1'b0;
            mem_berr <= 1'b0;
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_rf_we <= ex_rf_we;
                            wb_rf_wa <= ex_rf_wa;
                            wb_rf_wd <= ex_alu_res;
                        end else if (misaligned) begin
                            mem_ale  <= 1'b1;
                            wb_valid <= 1'b1;
                            wb_rf_we <= 1'b0;
                            wb_rf_wa <= ex_rf_wa;
                            wb_rf_wd <= ex_alu_res;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_addr  <= {ex_alu_res[31:2], 2'b00};
                            dmem_we    <= st_we;
                            dmem_wdata <= st_wdata;
                            op_q       <= ex_mem_op;
                            off_q      <= ex_alu_res[1:0];
                            rf_we_q    <= ex_rf_we;
                            rf_wa_q    <= ex_rf_wa;
                            cnt        <= '0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 4'b0;
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rf_we <= op_q[3] & rf_we_q;
                        wb_rf_wa <= rf_wa_q;
                        wb_rf_wd <= op_q[3] ? ld_data : 32'b0;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 4'b0;
                        state    <= IDLE;
                        mem_berr <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_rf_we <= 1'b0;
                        wb_rf_wa <= rf_wa_q;
                        wb_rf_wd <= {dmem_addr[31:2], off_q};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: writeback results are queued as expectations
// when an instruction is driven and checked by a monitor when wb_valid appears.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_res;
    logic [31:0] ex_st_data;
    logic [3:0]  ex_mem_op;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_wa;
    logic        mem_ready;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_rf_we;
    logic [4:0]  wb_rf_wa;
    logic [31:0] wb_rf_wd;
    logic        mem_ale;
    logic        mem_berr;

    always #5 clk = ~clk;

    mem_access_stage #(.DMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_st_data(ex_st_data),
        .ex_mem_op(ex_mem_op), .ex_rf_we(ex_rf_we), .ex_rf_wa(ex_rf_wa),
        .mem_ready(mem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rf_wa(wb_rf_wa),
        .wb_rf_wd(wb_rf_wd), .mem_ale(mem_ale), .mem_berr(mem_berr)
    );

    typedef struct {
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wa;
        logic        ale;
        logic        berr;
        logic        chk_wd;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] wd, input logic we, input logic [4:0] wa,
                            input logic ale, input logic berr, input logic chk_wd);
        exp_t e;
        e.wd = wd; e.we = we; e.wa = wa; e.ale = ale; e.berr = berr; e.chk_wd = chk_wd;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wa, input logic we);
        ex_valid   = 1'b1;
        ex_mem_op  = op;
        ex_alu_res = addr;
        ex_st_data = sdata;
        ex_rf_wa   = wa;
        ex_rf_we   = we;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("wb_unexpected", {31'b0, wb_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wb_rf_we", {31'b0, wb_rf_we}, {31'b0, e.we});
                    if (e.we) check("wb_rf_wa", {27'b0, wb_rf_wa}, {27'b0, e.wa});
                    if (e.chk_wd) check("wb_rf_wd", wb_rf_wd, e.wd);
                    check("mem_ale", {31'b0, mem_ale}, {31'b0, e.ale});
                    check("mem_berr", {31'b0, mem_berr}, {31'b0, e.berr});
                end
            end else begin
                check("ale_quiet", {31'b0, mem_ale}, 32'd0);
                check("berr_quiet", {31'b0, mem_berr}, 32'd0);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        ex_valid   = 1'b0;
        ex_alu_res = 32'b0;
        ex_st_data = 32'b0;
        ex_mem_op  = 4'b0;
        ex_rf_we   = 1'b0;
        ex_rf_wa   = 5'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'b0;
        repeat (3) tick;
        check("rst_ready", {31'b0, mem_ready}, 32'd1);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        check("rst_we", {28'b0, dmem_we}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_wb_wd", wb_rf_wd, 32'd0);
        check("rst_ale", {31'b0, mem_ale}, 32'd0);
        check("rst_berr", {31'b0, mem_berr}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // ALU pass-through, back to back
        for (int i = 1; i <= 3; i++) begin
            drive(4'b0000, 32'h11 * i, 32'h0, 5'd5, 1'b1);
            push_exp(32'h11 * i, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
            check("pt_ready", {31'b0, mem_ready}, 32'd1);
            tick;
        end
        ex_valid = 1'b0;
        tick;

        // LD.B then LD.BU at 0x1003, ack on third busy cycle
        for (int k = 0; k < 2; k++) begin
            drive(k == 0 ? 4'b1000 : 4'b1100, 32'h1003, 32'h0, 5'd7, 1'b1);
            push_exp(k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
            tick;
            ex_valid   = 1'b0;
            dmem_rdata = 32'h80FF_1234;
            check("ldb_req", {31'b0, dmem_req}, 32'd1);
            check("ldb_addr", dmem_addr, 32'h1000);
            check("ldb_we", {28'b0, dmem_we}, 32'd0);
            check("ldb_ready", {31'b0, mem_ready}, 32'd0);
            tick;
            tick;
            check("ldb_ready_c3", {31'b0, mem_ready}, 32'd0);
            dmem_ack = 1'b1;
            tick;
            dmem_ack = 1'b0;
            check("ldb_req_done", {31'b0, dmem_req}, 32'd0);
            check("ldb_ready_done", {31'b0, mem_ready}, 32'd1);
        end

        // ST.H at 0x2002, ack on first busy cycle
        drive(4'b0101, 32'h2002, 32'hDEAD_BEEF, 5'd9, 1'b1);
        push_exp(32'h0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
        tick;
        ex_valid = 1'b0;
        check("sth_req", {31'b0, dmem_req}, 32'd1);
        check("sth_addr", dmem_addr, 32'h2000);
        check("sth_we", {28'b0, dmem_we}, 32'hC);
        check("sth_wdata", dmem_wdata, 32'hBEEF_BEEF);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        check("sth_req_done", {31'b0, dmem_req}, 32'd0);
        check("sth_we_done", {28'b0, dmem_we}, 32'd0);

        // LD.W misaligned at 0x3001
        drive(4'b1010, 32'h3001, 32'h0, 5'd3, 1'b1);
        push_exp(32'h0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick;
        ex_valid = 1'b0;
        check("ale_noreq", {31'b0, dmem_req}, 32'd0);
        check("ale_ready", {31'b0, mem_ready}, 32'd1);
        check("ale_pulse", {31'b0, mem_ale}, 32'd1);
        tick;
        check("ale_one_cycle", {31'b0, mem_ale}, 32'd0);

        // LD.H at 0x3002: upper half, sign-extended
        drive(4'b1001, 32'h3002, 32'h0, 5'd3, 1'b1);
        push_exp(32'hFFFF_8001, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        tick;
        ex_valid   = 1'b0;
        dmem_rdata = 32'h8001_5555;
        check("ldh_addr", dmem_addr, 32'h3000);
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;

        // ST.W with no ack: times out after four request cycles
        drive(4'b0110, 32'h4000, 32'h1234_5678, 5'd0, 1'b0);
        push_exp(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick;
        ex_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("to_req", {31'b0, dmem_req}, 32'd1);
            tick;
        end
        check("to_req_drop", {31'b0, dmem_req}, 32'd0);
        check("to_berr", {31'b0, mem_berr}, 32'd1);
        check("to_ready", {31'b0, mem_ready}, 32'd1);
        tick;
        check("to_berr_one", {31'b0, mem_berr}, 32'd0);

        // Same store, ack on the last allowed cycle wins over timeout
        drive(4'b0110, 32'h4000, 32'h1234_5678, 5'd0, 1'b0);
        push_exp(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick;
        ex_valid = 1'b0;
        check("to2_wdata", dmem_wdata, 32'h1234_5678);
        check("to2_we", {28'b0, dmem_we}, 32'hF);
        for (int c = 0; c < 4; c++) begin
            check("to2_req", {31'b0, dmem_req}, 32'd1);
            if (c == 3) dmem_ack = 1'b1;
            tick;
        end
        dmem_ack = 1'b0;
        check("to2_req_drop", {31'b0, dmem_req}, 32'd0);
        check("to2_noberr", {31'b0, mem_berr}, 32'd0);
        check("to2_ready", {31'b0, mem_ready}, 32'd1);

        // Stray ack while idle
        dmem_ack = 1'b1;
        tick;
        dmem_ack = 1'b0;
        check("idle_ack_ready", {31'b0, mem_ready}, 32'd1);
        check("idle_ack_req", {31'b0, dmem_req}, 32'd0);
        check("idle_ack_wb", {31'b0, wb_valid}, 32'd0);

        // Reset two cycles into a busy load, with ack during reset
        drive(4'b1010, 32'h5000, 32'h0, 5'd4, 1'b1);
        tick;
        ex_valid   = 1'b0;
        dmem_rdata = 32'hCAFE_F00D;
        tick;
        rst      = 1'b1;
        dmem_ack = 1'b1;
        tick;
        rst      = 1'b0;
        dmem_ack = 1'b0;
        check("rstb_req", {31'b0, dmem_req}, 32'd0);
        check("rstb_wb", {31'b0, wb_valid}, 32'd0);
        check("rstb_ready", {31'b0, mem_ready}, 32'd1);
        check("rstb_addr", dmem_addr, 32'd0);
        tick;
        check("rstb_wb_after", {31'b0, wb_valid}, 32'd0);

        repeat (2) tick;
        check("sb_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
